// File: rtl/clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_gate_ctrl
// Brief    : Per-channel clock-gating controller. Every channel gates itself
//            off after a programmable idle period, using a stop-request /
//            acknowledge handshake. It wakes on activity, an explicit request
//            or a global override, and reports a stable clock on wake_ack.
// Revision : 1.0 - initial release
// ============================================================================
module clk_gate_ctrl #(
    parameter int NCH      = 4,
    parameter int IDLE_W   = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [IDLE_W-1:0] cfg_idle_thr,
    input  logic [NCH-1:0]    cfg_auto_en,
    input  logic              force_on,
    input  logic              scan_mode,
    input  logic [NCH-1:0]    busy,
    input  logic [NCH-1:0]    wake_req,
    input  logic [NCH-1:0]    stop_ack,
    output logic [NCH-1:0]    stop_req,
    output logic [NCH-1:0]    wake_ack,
    output logic [NCH-1:0]    gate_en,
    output logic [NCH-1:0]    gate_se,
    output logic [2*NCH-1:0]  ch_state
);

    localparam logic [1:0] c_RUN  = 2'd0;
    localparam logic [1:0] c_STOP = 2'd1;
    localparam logic [1:0] c_OFF  = 2'd2;
    localparam logic [1:0] c_WAKE = 2'd3;

    // Last wake-counter value before WAKE hands over to RUN.
    localparam logic [3:0] c_WAKE_LAST = 4'(WAKE_CYC - 1);

    // A zero threshold disables auto-gating on every channel.
    logic w_thr_zero;
    assign w_thr_zero = (cfg_idle_thr == '0);

    // Scan enable on the gate cells follows scan_mode directly.
    assign gate_se = {NCH{scan_mode}};

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [1:0]        r_state;
        logic [1:0]        w_nxt;
        logic [IDLE_W-1:0] r_cnt;
        logic [IDLE_W-1:0] w_cnt_nxt;
        logic [IDLE_W:0]   w_cnt_inc;
        logic [3:0]        r_wcnt;
        logic [3:0]        w_wcnt_nxt;
        logic              w_hold;
        logic              r_gate_en;
        logic              r_wake_ack;
        logic              r_stop_req;

        // Any reason to keep (or bring) this channel's clock on.
        assign w_hold = busy[i] | wake_req[i] | force_on | scan_mode
                      | ~cfg_auto_en[i] | w_thr_zero;

        // One bit wider so the threshold compare never wraps.
        assign w_cnt_inc = {1'b0, r_cnt} + (IDLE_W+1)'(1);

        // Next-state and counter update for this channel.
        always_comb begin
            w_nxt      = r_state;
            w_cnt_nxt  = r_cnt;
            w_wcnt_nxt = r_wcnt;
            case (r_state)
                c_RUN: begin
                    if (w_hold) begin
                        w_cnt_nxt = '0;
                    end else begin
                        if (r_cnt != '1) begin
                            w_cnt_nxt = w_cnt_inc[IDLE_W-1:0];
                        end
                        // >= so a threshold lowered mid-count acts at once.
                        if (w_cnt_inc >= {1'b0, cfg_idle_thr}) begin
                            w_nxt = c_STOP;
                        end
                    end
                end
                c_STOP: begin
                    // Renewed activity wins over an acknowledge on the same cycle.
                    if (w_hold) begin
                        w_nxt     = c_RUN;
                        w_cnt_nxt = '0;
                    end else if (stop_ack[i]) begin
                        w_nxt = c_OFF;
                    end
                end
                c_OFF: begin
                    if (w_hold) begin
                        w_nxt      = c_WAKE;
                        w_wcnt_nxt = '0;
                    end
                end
                c_WAKE: begin
                    // Settle period; never aborted.
                    if (r_wcnt >= c_WAKE_LAST) begin
                        w_nxt      = c_RUN;
                        w_cnt_nxt  = '0;
                        w_wcnt_nxt = '0;
                    end else begin
                        w_wcnt_nxt = r_wcnt + 4'd1;
                    end
                end
                default: begin
                    w_nxt     = c_RUN;
                    w_cnt_nxt = '0;
                end
            endcase
        end

        // State, counters and outputs decoded from the next state.
        always_ff @(posedge clk) begin
            if (!rst_b) begin
                r_state    <= c_RUN;
                r_cnt      <= '0;
                r_wcnt     <= '0;
                r_gate_en  <= 1'b1;
                r_wake_ack <= 1'b1;
                r_stop_req <= 1'b0;
            end else begin
                r_state    <= w_nxt;
                r_cnt      <= w_cnt_nxt;
                r_wcnt     <= w_wcnt_nxt;
                r_gate_en  <= (w_nxt != c_OFF);
                r_wake_ack <= (w_nxt == c_RUN);
                r_stop_req <= (w_nxt == c_STOP);
            end
        end

        assign gate_en[i]        = r_gate_en;
        assign wake_ack[i]       = r_wake_ack;
        assign stop_req[i]       = r_stop_req;
        assign ch_state[2*i +: 2] = r_state;
    end

endmodule
`default_nettype wire
